// File: rtl/free_list_pkg.sv
// Shared CPU sizing for the rename / free-list slice.
package free_list_pkg;

  localparam int CPU_PRF_NUM = 64;
  localparam int CPU_ARF_NUM = 32;
  localparam int CPU_PRF_IDX = $clog2(CPU_PRF_NUM);

  typedef logic [CPU_PRF_IDX-1:0] prf_idx_t;

  // Pointer width for a circular buffer of 'depth' entries, plus one wrap bit.
  function automatic int fl_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/free_list.sv
// Physical register free list. This is a circular buffer with a speculative
// allocation head, a committed head and a push tail. A flush rewinds the
// speculative head back to the committed head.
module free_list
  import free_list_pkg::*;
#(
  parameter  int PRF_NUM  = CPU_PRF_NUM,
  parameter  int ARF_NUM  = CPU_ARF_NUM,
  localparam int PRF_IDX  = $clog2(PRF_NUM),
  localparam int FL_DEPTH = PRF_NUM - ARF_NUM,
  localparam int PTR_W    = fl_ptr_w(FL_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  output logic [PRF_IDX-1:0] alloc_idx,
  input  logic               commit_valid,
  input  logic [PRF_IDX-1:0] commit_old_phy,
  input  logic               flush,
  output logic [PTR_W-1:0]   free_count
);

  localparam int IDX_W = PTR_W - 1;

  logic [PRF_IDX-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0]   head, cmt_head, tail;
  logic               pop_fire;
  logic [PTR_W-1:0]   spec_used;
  logic [PTR_W:0]     occ_sum;

  // Outputs come only from state. A same-cycle push is not bypassed to the head.
  assign free_count  = tail - head;
  assign alloc_ready = (free_count != '0);
  assign alloc_idx   = mem[head[IDX_W-1:0]];

  // Flush wins over a pop. A pop with nothing free is dropped.
  assign pop_fire = alloc_valid && alloc_ready && !flush;

  // Pointer update. Commit advances tail and cmt_head. A flush rewinds head
  // to the post-commit committed point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      cmt_head <= '0;
      tail     <= PTR_W'(FL_DEPTH);
    end else begin
      if (commit_valid) begin
        tail     <= tail + 1'b1;
        cmt_head <= cmt_head + 1'b1;
      end
      if (flush)
        head <= cmt_head + PTR_W'(commit_valid);
      else if (pop_fire)
        head <= head + 1'b1;
    end
  end

  // Buffer storage. Reset loads the initially free registers ARF_NUM..PRF_NUM-1.
  // A commit writes the reclaimed register at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        mem[i] <= PRF_IDX'(ARF_NUM + i);
    end else if (commit_valid) begin
      mem[tail[IDX_W-1:0]] <= commit_old_phy;
    end
  end

  // Ordering of the pointers: cmt_head <= head <= tail, in modular order.
  assign spec_used = head - cmt_head;
  assign occ_sum   = {1'b0, spec_used} + {1'b0, free_count};

  a_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    alloc_valid |-> alloc_ready);
  a_commit_when_full: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> (free_count != PTR_W'(FL_DEPTH)));
  a_ptr_order: assert property (@(posedge clk) disable iff (rst)
    occ_sum <= (PTR_W+1)'(FL_DEPTH));

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list. The reference model keeps the
// free registers and the uncommitted allocations as two queues.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic [5:0] alloc_idx;
  logic       commit_valid = 1'b0;
  logic [5:0] commit_old_phy = '0;
  logic       flush = 1'b0;
  logic [5:0] free_count;

  int total = 0;
  int bad   = 0;

  int free_q[$];
  int inflight_q[$];

  free_list dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .commit_valid(commit_valid), .commit_old_phy(commit_old_phy),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    free_q.delete();
    inflight_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one cycle, then updates the model. The caller guarantees legality.
  task automatic step(input bit p, input bit c, input int o, input bit f);
    int x;
    alloc_valid = p; commit_valid = c; commit_old_phy = 6'(o); flush = f;
    @(posedge clk); #1;
    alloc_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
    if (c) begin
      x = inflight_q.pop_front();
      free_q.push_back(o);
    end
    if (f) begin
      for (int i = inflight_q.size() - 1; i >= 0; i--) free_q.push_front(inflight_q[i]);
      inflight_q.delete();
    end else if (p) begin
      x = free_q.pop_front();
      inflight_q.push_back(x);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (alloc_idx !== 6'd32) begin bad++; $display("FAIL reset_idx got=%0d exp=32", alloc_idx); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", alloc_ready); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL reset_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      total++; if (alloc_idx !== 6'(32 + i)) begin bad++; $display("FAIL drain_idx[%0d] got=%0d exp=%0d", i, alloc_idx, 32 + i); end
      step(1, 0, 0, 0);
    end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%0b exp=0", alloc_ready); end
    total++; if (free_count !== 6'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", free_count); end
  endtask

  task automatic test_refill();
    // Commit into an empty list. The pushed register is not ready in the same cycle.
    alloc_valid = 1'b0; commit_valid = 1'b1; commit_old_phy = 6'd5;
    #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL refill_nobypass got=%0b exp=0", alloc_ready); end
    step(0, 1, 5, 0);
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL refill_ready got=%0b exp=1", alloc_ready); end
    total++; if (alloc_idx !== 6'd5) begin bad++; $display("FAIL refill_idx got=%0d exp=5", alloc_idx); end
  endtask

  task automatic test_steady();
    int seen7 = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 7, 0);
      if (alloc_idx === 6'd7) seen7++;
      total++; if (free_count !== 6'(free_q.size())) begin bad++; $display("FAIL steady_count[%0d] got=%0d exp=%0d", i, free_count, free_q.size()); end
      total++; if (alloc_idx !== 6'(free_q[0])) begin bad++; $display("FAIL steady_idx[%0d] got=%0d exp=%0d", i, alloc_idx, free_q[0]); end
    end
    total++; if (free_count !== 6'd1) begin bad++; $display("FAIL steady_const got=%0d exp=1", free_count); end
    total++; if (seen7 == 0) begin bad++; $display("FAIL steady_seen7 got=%0d exp=>0", seen7); end
  endtask

  task automatic test_flush_rewind();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 2, 0);
    step(0, 0, 0, 1);
    total++; if (alloc_idx !== 6'd33) begin bad++; $display("FAIL flush_idx got=%0d exp=33", alloc_idx); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL flush_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_flush_commit_pop();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 9, 1);
    total++; if (alloc_idx !== 6'd33) begin bad++; $display("FAIL fcp_idx got=%0d exp=33", alloc_idx); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL fcp_count got=%0d exp=32", free_count); end
    // The reclaimed 9 sits at the back of the list.
    total++; if (free_q[31] != 9) begin bad++; $display("FAIL fcp_model_tail got=%0d exp=9", free_q[31]); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 1, 11, 0);
    #2 rst = 1'b1;
    #1;
    total++; if (alloc_idx !== 6'd32) begin bad++; $display("FAIL areset_idx got=%0d exp=32", alloc_idx); end
    total++; if (free_count !== 6'd32) begin bad++; $display("FAIL areset_count got=%0d exp=32", free_count); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b exp=1", alloc_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    bit p, c, f;
    for (int n = 0; n < 600; n++) begin
      p = (free_q.size() > 0) && ($urandom_range(0, 3) != 0);
      c = (inflight_q.size() > 0) && ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 24) == 0);
      step(p, c, $urandom_range(0, 63), f);
      total++; if (free_count !== 6'(free_q.size())) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, free_count, free_q.size()); end
      total++; if (alloc_ready !== (free_q.size() > 0)) begin bad++; $display("FAIL rand_ready[%0d] got=%0b exp=%0b", n, alloc_ready, free_q.size() > 0); end
      if (free_q.size() > 0) begin
        total++; if (alloc_idx !== 6'(free_q[0])) begin bad++; $display("FAIL rand_idx[%0d] got=%0d exp=%0d", n, alloc_idx, free_q[0]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_drain();
    test_refill();
    test_steady();
    test_flush_rewind();
    test_flush_commit_pop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
